// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared room encoding and counter width for the maze game
package game_pkg;

  localparam int MOVE_W_DEF = 8;

  // One-hot room codes; bit position order defines the room output bus.
  typedef enum logic [6:0] {
    CAVE      = 7'b0000001,
    TUNNEL    = 7'b0000010,
    RIVER     = 7'b0000100,
    STASH     = 7'b0001000,
    DEN       = 7'b0010000,
    VAULT     = 7'b0100000,
    GRAVEYARD = 7'b1000000
  } room_e;

  function automatic logic dir_valid(input logic [3:0] dir);
    return ($countones(dir) == 1);
  endfunction

endpackage

// File: rtl/sword_fsm.sv
// rtl/sword_fsm.sv - sticky sword flag, set by any clock edge spent in the stash
module sword_fsm (
  input  logic clk,
  input  logic reset,
  input  logic in_stash,
  output logic sw
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw <= 1'b0;
    end else if (in_stash) begin
      sw <= 1'b1;
    end
  end

endmodule

// File: rtl/maze_game.sv
// rtl/maze_game.sv - room FSM with saturating move counter and sword pickup
module maze_game
  import game_pkg::*;
#(
  parameter int MOVE_W = MOVE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n,
  input  logic              s,
  input  logic              e,
  input  logic              w,
  output logic              d,
  output logic              win,
  output logic [6:0]        room,
  output logic              sw,
  output logic [MOVE_W-1:0] moves
);

  room_e      state;
  room_e      next;
  logic       valid;
  logic       stepped;
  logic [3:0] dir;

  assign dir   = {n, s, e, w};
  assign valid = dir_valid(dir);
  assign room  = state;

  sword_fsm u_sword (
    .clk      (clk),
    .reset    (reset),
    .in_stash (state == STASH),
    .sw       (sw)
  );

  always_comb begin
    next = state;
    case (state)
      CAVE:      if (valid && e) next = TUNNEL;
      TUNNEL: begin
        if (valid && w)      next = CAVE;
        else if (valid && s) next = RIVER;
      end
      RIVER: begin
        if (valid && w)      next = STASH;
        else if (valid && n) next = TUNNEL;
        else if (valid && e) next = DEN;
      end
      STASH:     if (valid && e) next = RIVER;
      // The den resolves on the registered sword, regardless of inputs.
      DEN:       next = sw ? VAULT : GRAVEYARD;
      VAULT:     next = VAULT;
      GRAVEYARD: next = GRAVEYARD;
      default:   next = CAVE;
    endcase
  end

  // Only player-driven room changes count; the den resolution is not a move.
  assign stepped = (state != DEN) && (next != state);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CAVE;
      d     <= 1'b0;
      win   <= 1'b0;
      moves <= '0;
    end else begin
      state <= next;
      d     <= (next == GRAVEYARD);
      win   <= (next == VAULT);
      if (stepped && (moves != {MOVE_W{1'b1}})) begin
        moves <= moves + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_maze_game.sv
// tb/tb_maze_game.sv - directed self-checking bench for maze_game
module tb_maze_game;

  localparam logic [6:0] R_CAVE   = 7'b0000001;
  localparam logic [6:0] R_TUNNEL = 7'b0000010;
  localparam logic [6:0] R_RIVER  = 7'b0000100;
  localparam logic [6:0] R_STASH  = 7'b0001000;
  localparam logic [6:0] R_DEN    = 7'b0010000;
  localparam logic [6:0] R_VAULT  = 7'b0100000;
  localparam logic [6:0] R_GRAVE  = 7'b1000000;

  localparam logic [3:0] D_N    = 4'b1000;
  localparam logic [3:0] D_S    = 4'b0100;
  localparam logic [3:0] D_E    = 4'b0010;
  localparam logic [3:0] D_W    = 4'b0001;
  localparam logic [3:0] D_NONE = 4'b0000;

  logic       clk = 1'b0;
  logic       reset;
  logic       n, s, e, w;
  logic       d, win, sw;
  logic [6:0] room;
  logic [7:0] moves;
  logic       d2, win2, sw2;
  logic [6:0] room2;
  logic [1:0] moves2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  maze_game dut (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .d(d), .win(win), .room(room), .sw(sw), .moves(moves)
  );

  maze_game #(.MOVE_W(2)) dut2 (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .d(d2), .win(win2), .room(room2), .sw(sw2), .moves(moves2)
  );

  task automatic step(input logic [3:0] dir);
    {n, s, e, w} = dir;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    {n, s, e, w} = D_E;
    repeat (3) @(posedge clk);
    #1;
    total++; if (room !== R_CAVE) begin bad++; $display("FAIL reset_room got=%b exp=%b", room, R_CAVE); end
    total++; if (moves !== 8'd0) begin bad++; $display("FAIL reset_moves got=%0d exp=0", moves); end
    total++; if ({sw, d, win} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {sw, d, win}); end
    reset = 1'b0;
    step(D_E);
    total++; if (room !== R_TUNNEL) begin bad++; $display("FAIL first_move_room got=%b exp=%b", room, R_TUNNEL); end
    total++; if (moves !== 8'd1) begin bad++; $display("FAIL first_move_moves got=%0d exp=1", moves); end
  endtask

  task automatic test_win;
    do_reset();
    step(D_E);
    step(D_S);
    total++; if (room !== R_RIVER) begin bad++; $display("FAIL win_river got=%b exp=%b", room, R_RIVER); end
    step(D_W);
    total++; if ({room, sw} !== {R_STASH, 1'b0}) begin bad++; $display("FAIL win_stash got=%b/%b exp=%b/0", room, sw, R_STASH); end
    step(D_E);
    total++; if ({room, sw} !== {R_RIVER, 1'b1}) begin bad++; $display("FAIL win_sword got=%b/%b exp=%b/1", room, sw, R_RIVER); end
    step(D_E);
    total++; if ({room, d, win} !== {R_DEN, 2'b00}) begin bad++; $display("FAIL win_den got=%b/%b%b exp=%b/00", room, d, win, R_DEN); end
    step(D_NONE);
    total++; if ({room, win, d, sw} !== {R_VAULT, 3'b101}) begin bad++; $display("FAIL win_vault got=%b/%b%b%b exp=%b/101", room, win, d, sw, R_VAULT); end
    total++; if (moves !== 8'd5) begin bad++; $display("FAIL win_moves got=%0d exp=5", moves); end
  endtask

  task automatic test_vault_hold;
    repeat (4) step(D_W);
    total++; if ({room, win, d} !== {R_VAULT, 2'b10}) begin bad++; $display("FAIL vault_hold got=%b/%b%b exp=%b/10", room, win, d, R_VAULT); end
    total++; if (moves !== 8'd5) begin bad++; $display("FAIL vault_moves got=%0d exp=5", moves); end
    reset = 1'b1;
    #1;
    total++; if ({room, sw, win} !== {R_CAVE, 2'b00}) begin bad++; $display("FAIL async_reset got=%b/%b%b exp=%b/00", room, sw, win, R_CAVE); end
    total++; if (moves !== 8'd0) begin bad++; $display("FAIL async_moves got=%0d exp=0", moves); end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_death;
    do_reset();
    step(D_E);
    step(D_S);
    step(D_E);
    total++; if (room !== R_DEN) begin bad++; $display("FAIL death_den got=%b exp=%b", room, R_DEN); end
    step(D_W);
    total++; if ({room, d, win, sw} !== {R_GRAVE, 3'b100}) begin bad++; $display("FAIL death_grave got=%b/%b%b%b exp=%b/100", room, d, win, sw, R_GRAVE); end
    total++; if (moves !== 8'd3) begin bad++; $display("FAIL death_moves got=%0d exp=3", moves); end
    step(D_E);
    total++; if ({room, d} !== {R_GRAVE, 1'b1}) begin bad++; $display("FAIL death_absorb got=%b/%b exp=%b/1", room, d, R_GRAVE); end
  endtask

  task automatic test_multi;
    do_reset();
    repeat (3) step(D_N | D_E);
    total++; if ({room, moves} !== {R_CAVE, 8'd0}) begin bad++; $display("FAIL multi_hold got=%b/%0d exp=%b/0", room, moves, R_CAVE); end
    step(D_NONE);
    step(D_N);
    total++; if ({room, moves} !== {R_CAVE, 8'd0}) begin bad++; $display("FAIL no_exit got=%b/%0d exp=%b/0", room, moves, R_CAVE); end
    step(D_E);
    total++; if ({room, moves} !== {R_TUNNEL, 8'd1}) begin bad++; $display("FAIL multi_then_e got=%b/%0d exp=%b/1", room, moves, R_TUNNEL); end
    step(D_E);
    total++; if ({room, moves} !== {R_TUNNEL, 8'd1}) begin bad++; $display("FAIL tunnel_e_hold got=%b/%0d exp=%b/1", room, moves, R_TUNNEL); end
    step(D_W);
    total++; if ({room, moves} !== {R_CAVE, 8'd2}) begin bad++; $display("FAIL tunnel_w got=%b/%0d exp=%b/2", room, moves, R_CAVE); end
  endtask

  task automatic test_loop;
    do_reset();
    step(D_E);
    step(D_S);
    step(D_N);
    total++; if ({room, moves} !== {R_TUNNEL, 8'd3}) begin bad++; $display("FAIL river_n got=%b/%0d exp=%b/3", room, moves, R_TUNNEL); end
  endtask

  task automatic test_saturate;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(D_E);
      step(D_W);
    end
    total++; if (moves2 !== 2'd3) begin bad++; $display("FAIL sat_moves got=%0d exp=3", moves2); end
    total++; if (room2 !== R_CAVE) begin bad++; $display("FAIL sat_room got=%b exp=%b", room2, R_CAVE); end
    total++; if (moves !== 8'd10) begin bad++; $display("FAIL wide_moves got=%0d exp=10", moves); end
  endtask

  initial begin
    reset = 1'b1;
    {n, s, e, w} = D_NONE;
    #50;
    test_reset();
    test_win();
    test_vault_hold();
    test_death();
    test_multi();
    test_loop();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
